// File: rtl/pipe_step_sequencer.sv
// pipe_step_sequencer
// UART-driven single-step / run controller for a pipelined CPU under debug.
// Command bytes from the UART select single steps, counted runs, unbounded
// runs, breakpoint arming and a timed pipeline reset. Every run ends by
// requesting a debug-bus dump and waiting for the transmitter to finish it.
//
// Ports
//   clock                   system clock, rising edge
//   reset                   asynchronous active-low reset
//   r_data[7:0]             received byte, valid while rx_ready=1
//   rx_ready                UART byte pending
//   pc_ifid[9:0]            IF/ID program counter for the breakpoint compare
//   program_finished        end-of-program flag
//   data_sent               one-cycle pulse when the bus dump has completed
//   rd_uart                 one-cycle byte-consumed pulse
//   pipe_clk_en             one-cycle pipeline advance (one step)
//   pipe_reset              pipeline reset, active high
//   clear_program_finished  one-cycle clear for the end detector
//   send_signal             one-cycle dump request
//   current_state[2:0]      FSM state for debug LEDs
//   step_count[15:0]        steps issued since the last pipeline reset
//   bp_valid                breakpoint armed
module pipe_step_sequencer #(
  parameter int PRST_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  r_data,
  input  logic        rx_ready,
  input  logic [9:0]  pc_ifid,
  input  logic        program_finished,
  input  logic        data_sent,
  output logic        rd_uart,
  output logic        pipe_clk_en,
  output logic        pipe_reset,
  output logic        clear_program_finished,
  output logic        send_signal,
  output logic [2:0]  current_state,
  output logic [15:0] step_count,
  output logic        bp_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARG_HI = 3'd1;
  localparam logic [2:0] S_ARG_LO = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DUMP   = 3'd4;
  localparam logic [2:0] S_PRST   = 3'd5;

  localparam logic [15:0] PRST_LAST = 16'(PRST_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic        rd_uart_q, rd_uart_d;
  logic [7:0]  remaining_q, remaining_d;
  logic        bounded_q, bounded_d;    // run stops when remaining hits 0
  logic        pulsed_q, pulsed_d;      // at least one step issued in this run
  logic        is_bp_q, is_bp_d;        // ARG_LO byte belongs to a 'b' command
  logic [9:0]  bp_pc_q, bp_pc_d;
  logic        bp_valid_q, bp_valid_d;
  logic [15:0] step_count_q, step_count_d;
  logic [15:0] prst_cnt_q, prst_cnt_d;

  logic accept;
  logic stop;
  logic run_pulse;

  // A byte is taken only when its previous consume pulse is not in flight,
  // so each UART byte is seen exactly once.
  assign accept = rx_ready & ~rd_uart_q;

  // All stop causes merge into one term, so coincident causes still yield a
  // single stop cycle and a single dump request.
  assign stop = (bounded_q && (remaining_q == 8'd0))
              || program_finished
              || (bp_valid_q && pulsed_q && (pc_ifid == bp_pc_q))
              || (accept && (r_data == 8'h68));

  assign run_pulse = (state_q == S_RUN) && !stop;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_uart_q    <= 1'b0;
      remaining_q  <= 8'd0;
      bounded_q    <= 1'b0;
      pulsed_q     <= 1'b0;
      is_bp_q      <= 1'b0;
      bp_pc_q      <= 10'd0;
      bp_valid_q   <= 1'b0;
      step_count_q <= 16'd0;
      prst_cnt_q   <= 16'd0;
    end else begin
      rd_uart_q    <= rd_uart_d;
      remaining_q  <= remaining_d;
      bounded_q    <= bounded_d;
      pulsed_q     <= pulsed_d;
      is_bp_q      <= is_bp_d;
      bp_pc_q      <= bp_pc_d;
      bp_valid_q   <= bp_valid_d;
      step_count_q <= step_count_d;
      prst_cnt_q   <= prst_cnt_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    rd_uart_d    = accept;
    remaining_d  = remaining_q;
    bounded_d    = bounded_q;
    pulsed_d     = pulsed_q;
    is_bp_d      = is_bp_q;
    bp_pc_d      = bp_pc_q;
    bp_valid_d   = bp_valid_q;
    step_count_d = run_pulse ? step_count_q + 16'd1 : step_count_q;
    prst_cnt_d   = prst_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (r_data)
            8'h73: begin state_d = S_RUN; bounded_d = 1'b1; remaining_d = 8'd1; pulsed_d = 1'b0; end
            8'h6E: begin state_d = S_ARG_LO; is_bp_d = 1'b0; end
            8'h72: begin state_d = S_RUN; bounded_d = 1'b0; pulsed_d = 1'b0; end
            8'h62: begin state_d = S_ARG_HI; is_bp_d = 1'b1; end
            8'h63: bp_valid_d = 1'b0;
            8'h78: begin state_d = S_PRST; prst_cnt_d = 16'd0; end
            default: ;
          endcase
        end
      end
      S_ARG_HI: begin
        if (accept) begin
          bp_pc_d[9:8] = r_data[1:0];
          state_d      = S_ARG_LO;
        end
      end
      S_ARG_LO: begin
        if (accept) begin
          if (is_bp_q) begin
            bp_pc_d[7:0] = r_data;
            bp_valid_d   = 1'b1;
            state_d      = S_IDLE;
          end else if (r_data == 8'd0) begin
            state_d = S_DUMP;
          end else begin
            state_d     = S_RUN;
            bounded_d   = 1'b1;
            remaining_d = r_data;
            pulsed_d    = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DUMP;
        end else begin
          pulsed_d = 1'b1;
          if (bounded_q) remaining_d = remaining_q - 8'd1;
        end
      end
      S_DUMP: begin
        if (data_sent) state_d = S_IDLE;
      end
      S_PRST: begin
        step_count_d = 16'd0;
        prst_cnt_d   = prst_cnt_q + 16'd1;
        if (prst_cnt_q >= PRST_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    rd_uart                = rd_uart_q;
    pipe_clk_en            = run_pulse;
    pipe_reset             = (state_q == S_PRST);
    // First RUN cycle is the only one with no step issued yet.
    clear_program_finished = ((state_q == S_RUN) && !pulsed_q)
                          || ((state_q == S_PRST) && (prst_cnt_q == 16'd0));
    // A zero-length counted run requests its dump straight from ARG_LO.
    send_signal            = ((state_q == S_RUN) && stop)
                          || ((state_q == S_ARG_LO) && accept && !is_bp_q && (r_data == 8'd0));
    current_state          = state_q;
    step_count             = step_count_q;
    bp_valid               = bp_valid_q;
  end

endmodule

// File: doc/pipe_step_sequencer.md
PIPE_STEP_SEQUENCER -- requirements
Module: pipe_step_sequencer

Interface
REQ-001 Parameter: PRST_CYCLES, default 4, number of cycles pipe_reset is held high per 'x' command.
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 r_data  in  8  received UART byte, valid while rx_ready=1.
REQ-005 rx_ready  in  1  UART receive byte pending; cleared by the UART after rd_uart.
REQ-006 pc_ifid  in  10  pipeline PC in the IF/ID register, for breakpoint compare.
REQ-007 program_finished  in  1  end-of-program flag from the end detector.
REQ-008 data_sent  in  1  one-cycle pulse from the debug transmitter when the bus dump is complete.
REQ-009 rd_uart  out  1  one-cycle byte-consumed pulse to the UART.
REQ-010 pipe_clk_en  out  1  one-cycle pipeline advance pulse; one pulse equals one pipeline step.
REQ-011 pipe_reset  out  1  pipeline reset, active high.
REQ-012 clear_program_finished  out  1  one-cycle pulse clearing the end detector.
REQ-013 send_signal  out  1  one-cycle pulse starting a debug-bus dump.
REQ-014 current_state  out  3  state encoding for debug LEDs.
REQ-015 step_count  out  16  pipe_clk_en pulses issued since the last pipeline reset.
REQ-016 bp_valid  out  1  breakpoint armed.

Function
REQ-017 States and encodings: IDLE=0, ARG_HI=1, ARG_LO=2, RUN=3, DUMP=4, PRST=5; codes 6 and 7 are unreachable and SHALL recover to IDLE.
REQ-018 Byte acceptance: a byte is accepted on the edge where rx_ready=1 and rd_uart=0; rd_uart is 1 on the next cycle only, and a byte is accepted in every state.
REQ-019 IDLE commands: 0x73 's' = run 1 step; 0x6E 'n' = go to ARG_LO for count N; 0x72 'r' = run unbounded; 0x62 'b' = go to ARG_HI for breakpoint; 0x63 'c' = clear bp_valid, stay in IDLE; 0x78 'x' = go to PRST; any other byte is discarded with no state change.
REQ-020 'b' sequence: the ARG_HI byte supplies bp_pc[9:8] (from bits [1:0]; upper bits ignored); the ARG_LO byte supplies bp_pc[7:0]; then bp_valid=1 and the state returns to IDLE.
REQ-021 'n' sequence: the ARG_LO byte is N; N=0 issues no pulse and goes directly to DUMP; otherwise the block goes to RUN with remaining=N.
REQ-022 RUN: on entry, clear_program_finished pulses once; pipe_clk_en=1 on every RUN cycle until a stop condition is met.
REQ-023 Stop conditions, evaluated each RUN cycle before a pulse is issued:
  - remaining reaches 0 (bounded runs);
  - program_finished=1;
  - bp_valid=1 and pc_ifid==bp_pc, after at least one pulse has been issued in this run;
  - byte 0x68 'h' is accepted.
REQ-024 On stop, no pulse is issued that cycle; send_signal=1 for exactly one cycle; the state goes to DUMP.
REQ-025 Simultaneous stop conditions SHALL produce exactly one send_signal.
REQ-026 Non-'h' bytes accepted in RUN are discarded.
REQ-027 DUMP: wait for data_sent=1, then go to IDLE; all bytes accepted in DUMP are discarded.
REQ-028 PRST: pipe_reset=1 for PRST_CYCLES cycles; step_count=0; clear_program_finished pulses on the first PRST cycle; then go to IDLE; bytes accepted in PRST are discarded.
REQ-029 step_count increments by 1 per pipe_clk_en and wraps 0xFFFF -> 0x0000.
REQ-030 Bounded-run count: remaining decrements per pulse, so N pulses are issued exactly, N being 1..255.

Reset
REQ-031 On reset=0, asynchronously and regardless of state: state=IDLE, all outputs=0, step_count=0, bp_valid=0, bp_pc=0, remaining=0.
REQ-032 Reset asserted mid-RUN or mid-DUMP SHALL abort with no further pulses; the next operation starts from IDLE.

Verification
REQ-033 Byte 's' -> exactly 1 pipe_clk_en, then 1 send_signal; step_count=1; after a data_sent pulse, current_state=0.
REQ-034 'n' then 0x05 -> 5 consecutive pipe_clk_en pulses, step_count=5, one send_signal; 'n' then 0x00 -> 0 pulses and one send_signal.
REQ-035 'b',0x01,0x20 then 'r', with pc_ifid reaching 0x120 on step 7 -> exactly 7 pulses; issuing 'r' again at pc_ifid=0x120 -> at least 1 pulse before the breakpoint can stop the run.
REQ-036 'r' with program_finished and 'h' in the same cycle -> exactly one send_signal; 's' during DUMP -> rd_uart pulses, no pulse issued.
REQ-037 'x' -> pipe_reset high for 4 cycles, step_count=0, one clear_program_finished pulse.
REQ-038 reset=0 mid-'n' 0xFF run -> outputs 0 immediately, bp_valid=0, current_state=0.
